// File: rtl/pwm_display_pkg.sv
// Shared types and constants for the PWM board display scheduler.
// The FSM encoding leaves 2'd3 unused; the scheduler recovers from it to BASE.
package pwm_display_pkg;

  typedef enum logic [1:0] {
    BASE    = 2'd0,
    AVISO_I = 2'd1,
    AVISO_F = 2'd2
  } estado_t;

  localparam logic SEL_CORRIENTE  = 1'b0;
  localparam logic SEL_FRECUENCIA = 1'b1;

  function automatic logic sel_de_estado(input estado_t st, input logic base);
    logic sel;
    case (st)
      AVISO_I: sel = SEL_CORRIENTE;
      AVISO_F: sel = SEL_FRECUENCIA;
      default: sel = base;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/planificador_display_antirrebote.sv
// Pushbutton conditioning: 2-flop synchronizer, debounce counter and press pulse.
// o_pulso is combinational so the press reaches the scheduler on the same edge it is accepted.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_boton,
  output logic o_pulso
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LIM  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_acc;
  logic [CW-1:0] r_cnt;
  logic          w_dif;
  logic          w_fin;

  // Acceptance decode and rising-edge pulse
  always_comb begin
    w_dif   = r_sync2 ^ r_acc;
    w_fin   = w_dif && (r_cnt == CNT_LIM);
    o_pulso = w_fin && r_sync2;
  end

  // Synchronizer, stability counter and accepted level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_acc   <= 1'b0;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_sync1 <= i_boton;
      r_sync2 <= r_sync1;
      if (!w_dif) begin
        r_cnt <= CNT_ZERO;
      end else if (w_fin) begin
        r_acc <= r_sync2;
        r_cnt <= CNT_ZERO;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/planificador_display.sv
// Display scheduler: base view chosen by button or auto-rotation, with timed
// notifications whenever the current or frequency setpoint changes.
module planificador_display
  import pwm_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 150000000,
  parameter int ROTATE_CYCLES   = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       boton_sel,
  input  logic       auto_en,
  input  logic [4:0] Corriente,
  input  logic [2:0] Frecuencia,
  output logic       selector_F_I,
  output logic       aviso,
  output logic [1:0] estado
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(ROTATE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_Z   = HW'(0);
  localparam logic [HW-1:0] HOLD_1   = HW'(1);
  localparam logic [RW-1:0] ROT_LIM  = RW'(ROTATE_CYCLES - 1);
  localparam logic [RW-1:0] ROT_Z    = RW'(0);
  localparam logic [RW-1:0] ROT_1    = RW'(1);

  estado_t       r_estado, w_estado;
  logic          r_base_sel, w_base_sel;
  logic          r_pend_i, w_pend_i;
  logic          r_pend_f, w_pend_f;
  logic [HW-1:0] r_hold, w_hold;
  logic [RW-1:0] r_rot, w_rot;
  logic          r_primer;
  logic [4:0]    r_prev_i;
  logic [2:0]    r_prev_f;
  logic          r_sel;
  logic          r_aviso;
  logic          w_pulso;
  logic          w_cambio_i;
  logic          w_cambio_f;

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_antirrebote (
    .clk    (clk),
    .rst    (rst),
    .i_boton(boton_sel),
    .o_pulso(w_pulso)
  );

  assign w_cambio_i   = ~r_primer & (Corriente != r_prev_i);
  assign w_cambio_f   = ~r_primer & (Frecuencia != r_prev_f);
  assign selector_F_I = r_sel;
  assign aviso        = r_aviso;
  assign estado       = r_estado;

  // Next-state: button press overrides everything, then per-state notification handling
  always_comb begin
    w_estado   = r_estado;
    w_base_sel = r_base_sel;
    w_pend_i   = r_pend_i;
    w_pend_f   = r_pend_f;
    w_hold     = r_hold;
    w_rot      = r_rot;
    if (w_pulso) begin
      w_base_sel = ~r_base_sel;
      w_estado   = BASE;
      w_pend_i   = 1'b0;
      w_pend_f   = 1'b0;
      w_hold     = HOLD_Z;
      w_rot      = ROT_Z;
    end else begin
      case (r_estado)
        BASE: begin
          if (w_cambio_i) begin
            w_estado = AVISO_I;
            w_hold   = HOLD_Z;
            w_pend_f = r_pend_f | w_cambio_f;
          end else if (w_cambio_f) begin
            w_estado = AVISO_F;
            w_hold   = HOLD_Z;
          end else if (auto_en) begin
            if (r_rot == ROT_LIM) begin
              w_base_sel = ~r_base_sel;
              w_rot      = ROT_Z;
            end else begin
              w_rot = r_rot + ROT_1;
            end
          end else begin
            w_rot = ROT_Z;
          end
        end
        AVISO_I: begin
          w_pend_f = r_pend_f | w_cambio_f;
          if (w_cambio_i) begin
            w_hold = HOLD_Z;
          end else if (r_hold == HOLD_LIM) begin
            w_hold = HOLD_Z;
            if (r_pend_f || w_cambio_f) begin
              w_pend_f = 1'b0;
              w_estado = AVISO_F;
            end else begin
              w_estado = BASE;
              w_rot    = ROT_Z;
            end
          end else begin
            w_hold = r_hold + HOLD_1;
          end
        end
        AVISO_F: begin
          w_pend_i = r_pend_i | w_cambio_i;
          if (w_cambio_f) begin
            w_hold = HOLD_Z;
          end else if (r_hold == HOLD_LIM) begin
            w_hold = HOLD_Z;
            if (r_pend_i || w_cambio_i) begin
              w_pend_i = 1'b0;
              w_estado = AVISO_I;
            end else begin
              w_estado = BASE;
              w_rot    = ROT_Z;
            end
          end else begin
            w_hold = r_hold + HOLD_1;
          end
        end
        default: begin
          w_estado = BASE;
          w_pend_i = 1'b0;
          w_pend_f = 1'b0;
          w_hold   = HOLD_Z;
          w_rot    = ROT_Z;
        end
      endcase
    end
  end

  // State, counters, change-detection history and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado   <= BASE;
      r_base_sel <= SEL_CORRIENTE;
      r_pend_i   <= 1'b0;
      r_pend_f   <= 1'b0;
      r_hold     <= HOLD_Z;
      r_rot      <= ROT_Z;
      r_primer   <= 1'b1;
      r_prev_i   <= 5'd0;
      r_prev_f   <= 3'd0;
      r_sel      <= SEL_CORRIENTE;
      r_aviso    <= 1'b0;
    end else begin
      r_estado   <= w_estado;
      r_base_sel <= w_base_sel;
      r_pend_i   <= w_pend_i;
      r_pend_f   <= w_pend_f;
      r_hold     <= w_hold;
      r_rot      <= w_rot;
      r_primer   <= 1'b0;
      r_prev_i   <= Corriente;
      r_prev_f   <= Frecuencia;
      r_sel      <= sel_de_estado(w_estado, w_base_sel);
      r_aviso    <= (w_estado != BASE);
    end
  end

endmodule
